// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (fetch/data) and memory-port signals for mem_port_arbiter.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_valid;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;

  logic                  err;
  logic                  stall_f;
  logic                  stall_m;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_rdata, i_valid, d_rdata, d_valid, err, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid, err, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data requesters onto one variable-latency memory port with an ack timeout.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed priority (data over fetch).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_valid_q, i_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef ARB_RR_EN
  logic                last_d_q, last_d_d;
`endif

  logic i_elig, d_elig, grant_i, grant_d, timeout;

  always_comb begin
    // A requester whose valid is pulsing this cycle is still holding req; mask it.
    i_elig  = bus.i_req & ~i_valid_q;
    d_elig  = bus.d_req & ~d_valid_q;
`ifdef ARB_RR_EN
    grant_d = d_elig & (~i_elig | ~last_d_q);
`else
    grant_d = d_elig;
`endif
    grant_i = i_elig & ~grant_d;
    timeout = (cnt_q == CNT_W'(TIMEOUT));

    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
`ifdef ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_be;
          cnt_d       = '0;
`ifdef ARB_RR_EN
          last_d_d    = 1'b1;
`endif
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          cnt_d       = '0;
`ifdef ARB_RR_EN
          last_d_d    = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        // Ack beats a coincident timeout.
        if (bus.mem_ack || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          i_valid_d = 1'b1;
          err_d     = ~bus.mem_ack;
          i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY_D: begin
        if (bus.mem_ack || timeout) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          err_d     = ~bus.mem_ack;
          // Stores leave the load-data register untouched.
          if (!mem_we_q) d_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.err       = err_q;
  assign bus.stall_f   = bus.i_req & ~i_valid_q;
  assign bus.stall_m   = bus.d_req & ~d_valid_q;
endmodule
